// File: rtl/cpu_csr_pkg.sv
// ---------------------------------------------------------------------------
// cpu_csr_pkg
// Shared definitions for the Zicsr execute stage and the CSR register file:
//   - CSR address constants and the list of implemented addresses
//   - funct3 encodings of the CSR instructions
//   - FSM state encoding of the execute stage
// ---------------------------------------------------------------------------
package cpu_csr_pkg;

    localparam int CSR_XLEN   = 32;
    localparam int CSR_ADDR_W = 12;

    // Supervisor CSRs
    localparam logic [CSR_ADDR_W-1:0] CSR_SSTATUS   = 12'h100;
    localparam logic [CSR_ADDR_W-1:0] CSR_SIE       = 12'h104;
    localparam logic [CSR_ADDR_W-1:0] CSR_STVEC     = 12'h105;
    localparam logic [CSR_ADDR_W-1:0] CSR_SSCRATCH  = 12'h140;
    localparam logic [CSR_ADDR_W-1:0] CSR_SEPC      = 12'h141;
    localparam logic [CSR_ADDR_W-1:0] CSR_SCAUSE    = 12'h142;
    localparam logic [CSR_ADDR_W-1:0] CSR_STVAL     = 12'h143;
    localparam logic [CSR_ADDR_W-1:0] CSR_SIP       = 12'h144;
    localparam logic [CSR_ADDR_W-1:0] CSR_SATP      = 12'h180;
    // Machine CSRs
    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIP       = 12'h344;
    // Read-only counters and IDs (addr[11:10] == 2'b11)
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
    localparam logic [CSR_ADDR_W-1:0] CSR_TIME      = 12'hC01;
    localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

    localparam int CSR_IMPL_N = 24;

    localparam logic [CSR_ADDR_W-1:0] CSR_IMPL_LIST [CSR_IMPL_N] = '{
        CSR_SSTATUS, CSR_SIE, CSR_STVEC, CSR_SSCRATCH, CSR_SEPC, CSR_SCAUSE,
        CSR_STVAL, CSR_SIP, CSR_SATP,
        CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
        CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
        CSR_CYCLE, CSR_TIME, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH, CSR_MHARTID
    };

    // funct3 of the SYSTEM opcode; 000 and 100 are not CSR instructions.
    typedef enum logic [2:0] {
        F3_ILL0 = 3'b000,
        F3_RW   = 3'b001,
        F3_RS   = 3'b010,
        F3_RC   = 3'b011,
        F3_ILL4 = 3'b100,
        F3_RWI  = 3'b101,
        F3_RSI  = 3'b110,
        F3_RCI  = 3'b111
    } csr_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } csr_state_e;

    function automatic logic csr_is_implemented(input logic [CSR_ADDR_W-1:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < CSR_IMPL_N; i++) begin
            if (addr == CSR_IMPL_LIST[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/cpu_csr_addr_check.sv
// ---------------------------------------------------------------------------
// cpu_csr_addr_check
// Combinational CSR address decode, shared with trap/privilege logic.
// Ports:
//   addr        in   CSR address
//   wants_write in   the access will write the CSR
//   legal       out  address implemented and not a write to a read-only CSR
//   read_only   out  address lies in the read-only space (addr[11:10]==2'b11)
// ---------------------------------------------------------------------------
module cpu_csr_addr_check
    import cpu_csr_pkg::*;
(
    input  logic [CSR_ADDR_W-1:0] addr,
    input  logic                  wants_write,
    output logic                  legal,
    output logic                  read_only
);

    assign read_only = (addr[CSR_ADDR_W-1 -: 2] == 2'b11);
    assign legal     = csr_is_implemented(addr) && !(wants_write && read_only);

endmodule

// File: rtl/cpu_csr_unit.sv
// ---------------------------------------------------------------------------
// cpu_csr_unit
// Zicsr execute stage. Runs one CSRRW/RS/RC(I) as a read-modify-write on the
// CSR file interface and returns the old value for rd.
// Sequence: IDLE -> READ -> [WRITE] -> DONE -> IDLE.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   start               launch request, sampled only in IDLE
//   funct3, csr_sel     opcode and target CSR address
//   rs1_val, rs1_idx    register operand / rs1 index (uimm in immediate forms)
//   busy                high while an operation is in flight
//   done                one-cycle completion pulse; rd_val/illegal valid
//   rd_val, illegal     old CSR value (0 if illegal) and illegal flag
//   csr_addr, csr_wdata, csr_wr, csr_rdata   CSR file interface
// ---------------------------------------------------------------------------
module cpu_csr_unit
    import cpu_csr_pkg::*;
#(
    parameter int XLEN   = CSR_XLEN,
    parameter int ADDR_W = CSR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] csr_sel,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [4:0]        rs1_idx,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   rd_val,
    output logic              illegal,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_wr,
    input  logic [XLEN-1:0]   csr_rdata
);

    csr_state_e        r_state;
    csr_state_e        w_next_state;

    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_rs1_val;
    logic [4:0]        r_rs1_idx;
    logic [XLEN-1:0]   r_old;

    csr_funct3_e       w_f3;
    logic              w_accept;
    logic              w_f3_valid;
    logic              w_wants_write;
    logic              w_addr_legal;
    logic              w_read_only;
    logic              w_illegal;
    logic [XLEN-1:0]   w_src;
    logic [XLEN-1:0]   w_wdata;

    // -----------------------------------------------------------------------
    // Decode of the latched instruction; stable for the whole operation.
    // -----------------------------------------------------------------------
    assign w_f3       = csr_funct3_e'(r_funct3);
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_f3_valid = (r_funct3[1:0] != 2'b00);

    // RW forms always write; set/clear forms write only when rs1/uimm != 0.
    assign w_wants_write = w_f3_valid &&
                           ((r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0));

    assign w_src = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_val;

    cpu_csr_addr_check u_addr_check (
        .addr        (r_addr),
        .wants_write (w_wants_write),
        .legal       (w_addr_legal),
        .read_only   (w_read_only)
    );

    // Read-only handling is folded into w_addr_legal; the flag is exposed for
    // other users of the checker.
    logic w_unused;
    assign w_unused  = w_read_only;

    assign w_illegal = !w_f3_valid || !w_addr_legal;

    always_comb begin
        unique case (w_f3)
            F3_RS, F3_RSI: w_wdata = r_old | w_src;
            F3_RC, F3_RCI: w_wdata = r_old & ~w_src;
            default:       w_wdata = w_src;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // -----------------------------------------------------------------------
    // Operand capture and old-value register
    // -----------------------------------------------------------------------
    // NOTE: these are plain datapath flops, not a memory array, so they get
    // the async reset too and never carry X into rd_val or csr_wdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_funct3  <= '0;
            r_addr    <= '0;
            r_rs1_val <= '0;
            r_rs1_idx <= '0;
            r_old     <= '0;
        end else begin
            if (w_accept) begin
                r_funct3  <= funct3;
                r_addr    <= csr_sel;
                r_rs1_val <= rs1_val;
                r_rs1_idx <= rs1_idx;
            end
            if (r_state == ST_READ) r_old <= csr_rdata;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs. Outputs decode from the state register only, so
    // an asynchronous reset removes csr_wr in the same instant.
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        csr_addr     = '0;
        csr_wdata    = '0;
        csr_wr       = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        rd_val       = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_READ;
            end
            ST_READ: begin
                csr_addr = r_addr;
                if (w_illegal || !w_wants_write) w_next_state = ST_DONE;
                else                             w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                csr_addr     = r_addr;
                csr_wr       = 1'b1;
                csr_wdata    = w_wdata;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                illegal      = w_illegal;
                rd_val       = w_illegal ? '0 : r_old;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cpu_csr_unit.sv
module tb_cpu_csr_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_sel;
    logic [31:0] rs1_val;
    logic [4:0]  rs1_idx;
    logic        busy;
    logic        done;
    logic [31:0] rd_val;
    logic        illegal;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wr;
    logic [31:0] csr_rdata;

    int checks = 0;
    int errors = 0;

    // Simple CSR file model: combinational read, write on rising edge.
    logic [31:0] mem [0:4095];
    assign csr_rdata = mem[csr_addr];
    always @(posedge clk) begin
        if (csr_wr) mem[csr_addr] <= csr_wdata;
    end

    cpu_csr_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .csr_sel   (csr_sel),
        .rs1_val   (rs1_val),
        .rs1_idx   (rs1_idx),
        .busy      (busy),
        .done      (done),
        .rd_val    (rd_val),
        .illegal   (illegal),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_wr    (csr_wr),
        .csr_rdata (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation, scramble the inputs after the accepting edge, and
    // watch up to 8 cycles for done. Checks latency, rd_val, illegal and the
    // number / data of csr_wr pulses.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [11:0] sel,
                          input logic [31:0] v, input logic [4:0] idx,
                          input int exp_lat, input logic [31:0] exp_rd,
                          input logic exp_ill, input int exp_wr, input logic [31:0] exp_wdata);
        int lat;
        int wr_cnt;
        logic [31:0] wdata_seen;
        logic [31:0] rd_seen;
        logic ill_seen;
        logic [11:0] addr_done;
        lat = 0; wr_cnt = 0; wdata_seen = '0; rd_seen = 'x; ill_seen = 1'bx; addr_done = 'x;
        @(negedge clk);
        start = 1'b1; funct3 = f3; csr_sel = sel; rs1_val = v; rs1_idx = idx;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = 3'b000; csr_sel = 12'h000; rs1_val = ~v; rs1_idx = 5'd0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check({tag, ".busy"}, {31'b0, busy}, 32'd1);
                check({tag, ".read_addr"}, {20'b0, csr_addr}, {20'b0, sel});
            end
            if (csr_wr) begin
                wr_cnt++;
                wdata_seen = csr_wdata;
            end
            if (done) begin
                lat = cyc; rd_seen = rd_val; ill_seen = illegal; addr_done = csr_addr;
                break;
            end
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rd_val"}, rd_seen, exp_rd);
        check({tag, ".illegal"}, {31'b0, ill_seen}, {31'b0, exp_ill});
        check({tag, ".wr_pulses"}, wr_cnt, exp_wr);
        if (exp_wr != 0) check({tag, ".wdata"}, wdata_seen, exp_wdata);
        check({tag, ".done_addr"}, {20'b0, addr_done}, 32'd0);
    endtask

    initial begin
        int n_done;
        int n_wr;
        int done_cyc [5];
        logic prev_done;
        int double_done;
        int late_done;

        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h140] = 32'h0000_00F0;
        mem[12'h141] = 32'h1111_1111;
        mem[12'h340] = 32'h0000_0055;
        mem[12'hC00] = 32'h1234_5678;

        rst = 1'b0; start = 1'b0; funct3 = 3'b000; csr_sel = '0; rs1_val = '0; rs1_idx = '0;

        // Reset state
        #1;
        check("rst.busy",    {31'b0, busy},    32'd0);
        check("rst.done",    {31'b0, done},    32'd0);
        check("rst.illegal", {31'b0, illegal}, 32'd0);
        check("rst.csr_wr",  {31'b0, csr_wr},  32'd0);
        check("rst.rd_val",  rd_val,           32'd0);
        check("rst.addr",    {20'b0, csr_addr}, 32'd0);
        check("rst.wdata",   csr_wdata,        32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1: CSRRS sscratch, 0xF0 | 0x0F
        run_op("t1_csrrs", 3'b010, 12'h140, 32'h0000_000F, 5'd5, 3, 32'h0000_00F0, 1'b0, 1, 32'h0000_00FF);
        check("t1.file", mem[12'h140], 32'h0000_00FF);

        // 2: CSRRCI sscratch, uimm 0x10
        run_op("t2_csrrci", 3'b111, 12'h140, 32'hFFFF_FFFF, 5'h10, 3, 32'h0000_00FF, 1'b0, 1, 32'h0000_00EF);
        check("t2.file", mem[12'h140], 32'h0000_00EF);

        // 3: CSRRS cycle with rs1=x0: pure read of a read-only CSR is legal
        run_op("t3_rd_cycle", 3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0, 2, 32'h1234_5678, 1'b0, 0, 32'h0);

        // 4: illegal cases
        run_op("t4_rw_cycle", 3'b001, 12'hC00, 32'h0000_0001, 5'd3, 2, 32'h0, 1'b1, 0, 32'h0);
        check("t4.file", mem[12'hC00], 32'h1234_5678);
        run_op("t4_f3_100", 3'b100, 12'h140, 32'h0000_0001, 5'd1, 2, 32'h0, 1'b1, 0, 32'h0);
        run_op("t4_f3_000", 3'b000, 12'h140, 32'h0000_0001, 5'd1, 2, 32'h0, 1'b1, 0, 32'h0);
        run_op("t4_unimpl", 3'b010, 12'h7C0, 32'h0000_0001, 5'd1, 2, 32'h0, 1'b1, 0, 32'h0);

        // CSRRWI with uimm 0 still writes
        run_op("t4_rwi_zero", 3'b101, 12'h340, 32'hFFFF_FFFF, 5'd0, 3, 32'h0000_0055, 1'b0, 1, 32'h0);
        check("t4_rwi.file", mem[12'h340], 32'h0);

        // 5: reset asserted in the WRITE cycle of CSRRW sepc
        @(negedge clk);
        start = 1'b1; funct3 = 3'b001; csr_sel = 12'h141; rs1_val = 32'hDEAD_BEEF; rs1_idx = 5'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);               // READ
        @(negedge clk);               // WRITE
        check("t5.wr_before", {31'b0, csr_wr}, 32'd1);
        rst = 1'b0;
        #1;
        check("t5.wr_after",  {31'b0, csr_wr}, 32'd0);
        check("t5.busy",      {31'b0, busy},   32'd0);
        check("t5.done",      {31'b0, done},   32'd0);
        @(negedge clk);
        check("t5.file", mem[12'h141], 32'h1111_1111);
        rst = 1'b1;
        late_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) late_done++;
        end
        check("t5.no_done", late_done, 0);

        // 6: start held high continuously; one RW operation every 4 cycles
        funct3 = 3'b001; csr_sel = 12'h340; rs1_val = 32'h0000_A5A5; rs1_idx = 5'd2;
        start = 1'b1;
        n_done = 0; n_wr = 0; prev_done = 1'b0; double_done = 0;
        for (int i = 0; i < 5; i++) done_cyc[i] = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (csr_wr) n_wr++;
            if (done) begin
                if (prev_done) double_done++;
                if (n_done < 5) done_cyc[n_done] = cyc;
                n_done++;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("t6.n_done", n_done, 5);
        check("t6.n_wr", n_wr, 5);
        check("t6.double_done", double_done, 0);
        for (int i = 0; i < 5; i++) check("t6.done_cycle", done_cyc[i], 3 + 4 * i);
        check("t6.file", mem[12'h340], 32'h0000_A5A5);
        repeat (4) @(negedge clk);
        check("t6.idle_busy", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
